eth_rx_fcs_check: RTL and testbench

- Receive-side counterpart of the team's CRC-32 transmit path.
- Takes the byte stream from the GMII receive interface and strips the preamble and SFD.
- Runs the frame bytes plus the trailing FCS through the same CRC-32 polynomial, and forwards the payload with the 4 FCS bytes removed.
- Flags each frame good or bad at end of frame, and keeps good and bad frame counters for the control registers.

---
 rtl/eth_rx_fcs_check.sv | 179 +++++++++++++++++
 tb/tb_eth_rx_fcs_check.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_fcs_check.sv
// GMII receive front end: strips preamble/SFD, checks the CRC-32 residue and frame length,
// forwards the payload without its FCS and reports per-frame status with good/bad counters.
module eth_rx_fcs_check #(
  parameter int          MIN_LEN     = 64,
  parameter int          MAX_LEN     = 1518,
  parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rx_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        err_crc,
  output logic        err_len,
  output logic        err_phy,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_END  = 3'd3,
    S_DROP = 3'd4
  } state_t;

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  // Serial MSB-first CRC-32 step fed with the byte's bit 0 first (bit-reversed byte).
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) begin
        c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic [31:0]     r_crc;
  logic [15:0]     r_cnt;
  logic            r_phy;
  logic [4:0][7:0] r_dly;

  logic        w_sfd;
  logic        w_byte;
  logic        w_last;
  logic        w_hold;
  logic        w_crc_bad;
  logic        w_len_bad;
  logic        w_bad;
  logic [31:0] w_crc_next;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_dv) w_next = S_PRE;
        else       w_next = S_IDLE;
      end
      S_PRE: begin
        if (!rx_dv)                 w_next = S_IDLE;
        else if (rx_data == 8'h55) w_next = S_PRE;
        else if (rx_data == 8'hD5) w_next = S_DATA;
        else                        w_next = S_DROP;
      end
      S_DATA: begin
        if (!rx_dv) w_next = S_END;
        else        w_next = S_DATA;
      end
      S_END:  w_next = S_IDLE;
      S_DROP: begin
        if (!rx_dv) w_next = S_IDLE;
        else        w_next = S_DROP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-cycle decode and the end-of-frame verdict.
  always_comb begin
    w_sfd      = (r_state == S_PRE) && rx_dv && (rx_data == 8'hD5);
    w_byte     = (r_state == S_DATA) && rx_dv;
    w_last     = (r_state == S_DATA) && !rx_dv;
    w_hold     = (r_cnt >= 16'd5);
    w_crc_next = crc32_step(r_crc, rx_data);
    w_crc_bad  = (r_crc != CRC_RESIDUE);
    w_len_bad  = (r_cnt < 16'd5) || (r_cnt < MIN_L) || (r_cnt > MAX_L);
    w_bad      = w_crc_bad || w_len_bad || r_phy;
  end

  // Datapath: CRC, byte count, FCS-stripping delay line, registered outputs and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc     <= 32'hFFFF_FFFF;
      r_cnt     <= 16'd0;
      r_phy     <= 1'b0;
      r_dly     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_crc   <= 1'b0;
      err_len   <= 1'b0;
      err_phy   <= 1'b0;
      good_cnt  <= 16'd0;
      bad_cnt   <= 16'd0;
    end else begin
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_crc   <= 1'b0;
      err_len   <= 1'b0;
      err_phy   <= 1'b0;
      if (w_sfd) begin
        r_crc <= 32'hFFFF_FFFF;
        r_cnt <= 16'd0;
        r_phy <= 1'b0;
      end else if (w_byte) begin
        r_crc <= w_crc_next;
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        if (rx_er) r_phy <= 1'b1;
        r_dly <= {r_dly[3:0], rx_data};
        // The oldest entry leaves the line only once five newer bytes sit behind it.
        if (w_hold) begin
          out_valid <= 1'b1;
          out_data  <= r_dly[4];
          out_sof   <= (r_cnt == 16'd5);
        end
      end else if (w_last) begin
        if (w_hold) begin
          out_valid <= 1'b1;
          out_data  <= r_dly[4];
          out_sof   <= (r_cnt == 16'd5);
          out_eof   <= 1'b1;
        end
        if (w_bad) begin
          frame_err <= 1'b1;
          err_crc   <= w_crc_bad;
          err_len   <= w_len_bad;
          err_phy   <= r_phy;
          bad_cnt   <= bad_cnt + 16'd1;
        end else begin
          frame_ok  <= 1'b1;
          good_cnt  <= good_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench for eth_rx_fcs_check: one instance with MIN_LEN=13, one with defaults,
// both driven by the same GMII stream; a negedge monitor pops and compares expectations.
`timescale 1ns/1ps
module tb_eth_rx_fcs_check;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] rx_data;

  logic        ov   [2];
  logic [7:0]  od   [2];
  logic        osof [2];
  logic        oeof [2];
  logic        fok  [2];
  logic        ferr [2];
  logic        ecrc [2];
  logic        elen [2];
  logic        ephy [2];
  logic [15:0] gcnt [2];
  logic [15:0] bcnt [2];

  eth_rx_fcs_check #(.MIN_LEN(13)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
    .out_valid(ov[0]), .out_data(od[0]), .out_sof(osof[0]), .out_eof(oeof[0]),
    .frame_ok(fok[0]), .frame_err(ferr[0]), .err_crc(ecrc[0]), .err_len(elen[0]),
    .err_phy(ephy[0]), .good_cnt(gcnt[0]), .bad_cnt(bcnt[0]));

  eth_rx_fcs_check dut_b (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
    .out_valid(ov[1]), .out_data(od[1]), .out_sof(osof[1]), .out_eof(oeof[1]),
    .frame_ok(fok[1]), .frame_err(ferr[1]), .err_crc(ecrc[1]), .err_len(elen[1]),
    .err_phy(ephy[1]), .good_cnt(gcnt[1]), .bad_cnt(bcnt[1]));

  typedef struct packed {
    logic        ok;
    logic        crc;
    logic        len;
    logic        phy;
    logic [15:0] g;
    logic [15:0] b;
  } st_t;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  longint      cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [9:0] q_pay0 [$];
  logic [9:0] q_pay1 [$];
  st_t        q_st0  [$];
  st_t        q_st1  [$];

  logic [15:0] mg [2];
  logic [15:0] mb [2];
  int          min_len [2];

  logic [7:0] fr [0:1599];
  int         fr_n;
  bit         lat_arm  = 1'b0;
  bit         lat_pend = 1'b0;
  longint     lat_t0   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference CRC-32 in the reflected (LSB-first) form used on the wire.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ 32'hEDB8_8320;
      else      r = r >> 1;
    end
    return r;
  endfunction

  task automatic build_gen(input int npay, input int seed);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < npay; i++) begin
      fr[i] = 8'((i * 7 + seed * 13 + 3) & 255);
      r = crc_ref(r, fr[i]);
    end
    r = ~r;
    fr[npay]     = r[7:0];
    fr[npay + 1] = r[15:8];
    fr[npay + 2] = r[23:16];
    fr[npay + 3] = r[31:24];
    fr_n = npay + 4;
  endtask

  // Push the expected payload and status for the frame in fr[] into both scoreboards.
  task automatic expect_frame(input int er_idx);
    logic [31:0] r;
    logic        crc_bad;
    logic        len_bad;
    logic        phy;
    st_t         s;
    r = 32'hFFFF_FFFF;
    for (int i = 0; i < fr_n; i++) r = crc_ref(r, fr[i]);
    crc_bad = (r != 32'hDEBB_20E3);
    phy     = (er_idx >= 0) && (er_idx < fr_n);
    for (int i = 0; i <= fr_n - 5; i++) begin
      q_pay0.push_back({fr[i], i == 0, i == fr_n - 5});
      q_pay1.push_back({fr[i], i == 0, i == fr_n - 5});
    end
    for (int k = 0; k < 2; k++) begin
      len_bad = (fr_n < 5) || (fr_n < min_len[k]) || (fr_n > 1518);
      if (crc_bad || len_bad || phy) mb[k] = mb[k] + 16'd1;
      else                           mg[k] = mg[k] + 16'd1;
      s.ok  = !(crc_bad || len_bad || phy);
      s.crc = crc_bad;
      s.len = len_bad;
      s.phy = phy;
      s.g   = mg[k];
      s.b   = mb[k];
      if (k == 0) q_st0.push_back(s);
      else        q_st1.push_back(s);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic er);
    @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_data = d;
    rx_er   = er;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rx_dv   = 1'b0;
      rx_er   = 1'b0;
      rx_data = 8'h00;
    end
  endtask

  task automatic preamble();
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
  endtask

  task automatic send_frame(input int er_idx);
    expect_frame(er_idx);
    preamble();
    for (int i = 0; i < fr_n; i++) begin
      drive(fr[i], i == er_idx);
      if (i == 0 && lat_arm) begin
        lat_t0   = cyc;
        lat_pend = 1'b1;
        lat_arm  = 1'b0;
      end
    end
    idle(12);
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_out%0d", tag, k),
          {20'h0, ov[k], od[k], osof[k], oeof[k], fok[k], ferr[k]}, 32'h0);
      chk($sformatf("%s_err%0d", tag, k), {29'h0, ecrc[k], elen[k], ephy[k]}, 32'h0);
      chk($sformatf("%s_cnt%0d", tag, k), {gcnt[k], bcnt[k]}, 32'h0);
    end
  endtask

  // Monitor: pop and compare whenever an instance presents a payload byte or a status pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        logic [9:0] e;
        st_t        s;
        int         sz;
        if (ov[k]) begin
          sz = (k == 0) ? q_pay0.size() : q_pay1.size();
          if (sz == 0) begin
            chk($sformatf("spurious_out%0d", k), {31'h0, ov[k]}, 32'h0);
          end else begin
            if (k == 0) e = q_pay0.pop_front();
            else        e = q_pay1.pop_front();
            chk($sformatf("payload%0d", k), {22'h0, od[k], osof[k], oeof[k]}, {22'h0, e});
          end
          if (k == 0 && osof[k] && lat_pend) begin
            chk("sof_latency", 32'(cyc - lat_t0), 32'd6);
            lat_pend = 1'b0;
          end
        end
        if (fok[k] || ferr[k]) begin
          sz = (k == 0) ? q_st0.size() : q_st1.size();
          if (sz == 0) begin
            chk($sformatf("spurious_status%0d", k), {30'h0, fok[k], ferr[k]}, 32'h0);
          end else begin
            if (k == 0) s = q_st0.pop_front();
            else        s = q_st1.pop_front();
            chk($sformatf("status%0d", k),
                {27'h0, fok[k], ferr[k], ecrc[k], elen[k], ephy[k]},
                {27'h0, s.ok, !s.ok, s.crc, s.len, s.phy});
            chk($sformatf("good_cnt%0d", k), {16'h0, gcnt[k]}, {16'h0, s.g});
            chk($sformatf("bad_cnt%0d", k), {16'h0, bcnt[k]}, {16'h0, s.b});
          end
        end else if (ecrc[k] || elen[k] || ephy[k]) begin
          chk($sformatf("stray_err%0d", k), {29'h0, ecrc[k], elen[k], ephy[k]}, 32'h0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tv [13];
    tv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    min_len[0] = 13;
    min_len[1] = 64;
    mg[0] = 16'd0; mg[1] = 16'd0; mb[0] = 16'd0; mb[1] = 16'd0;
    rst_n = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    idle(3);

    // "123456789" with its published FCS, then the same with a corrupted last FCS byte.
    for (int i = 0; i < 13; i++) fr[i] = tv[i];
    fr_n = 13;
    lat_arm = 1'b1;
    send_frame(-1);
    fr[12] = 8'hCA;
    send_frame(-1);

    // Minimum-length boundary: 64 bytes legal, 63 bytes runt for the default instance.
    build_gen(60, 1);
    send_frame(-1);
    build_gen(59, 2);
    send_frame(-1);

    // PHY error on data byte 10.
    build_gen(60, 3);
    send_frame(10);

    // Corrupt preamble drops the frame, including a later SFD-looking byte.
    drive(8'h55, 1'b0);
    drive(8'h55, 1'b0);
    drive(8'h12, 1'b0);
    for (int i = 0; i < 3; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < 8; i++) drive(8'(8'hA0 + i), 1'b0);
    idle(8);
    build_gen(60, 4);
    send_frame(-1);

    // Three-byte runt: nothing forwarded, length error.
    fr[0] = 8'hA1; fr[1] = 8'hA2; fr[2] = 8'hA3;
    fr_n = 3;
    send_frame(-1);

    // Reset in the middle of DATA after 20 bytes (bytes 0..14 already forwarded).
    build_gen(60, 5);
    for (int i = 0; i <= 14; i++) begin
      q_pay0.push_back({fr[i], i == 0, 1'b0});
      q_pay1.push_back({fr[i], i == 0, 1'b0});
    end
    preamble();
    for (int i = 0; i < 20; i++) drive(fr[i], 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    rx_dv = 1'b0;
    #1;
    chk_zero("midreset");
    chk("midreset_queues",
        32'(q_pay0.size() + q_pay1.size() + q_st0.size() + q_st1.size()), 32'd0);
    mg[0] = 16'd0; mg[1] = 16'd0; mb[0] = 16'd0; mb[1] = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    build_gen(60, 6);
    send_frame(-1);

    idle(20);
    chk("drain_pay_a", 32'(q_pay0.size()), 32'd0);
    chk("drain_pay_b", 32'(q_pay1.size()), 32'd0);
    chk("drain_st_a", 32'(q_st0.size()), 32'd0);
    chk("drain_st_b", 32'(q_st1.size()), 32'd0);
    chk("latency_seen", {31'h0, lat_pend}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
